// File: rtl/zynq_aes.sv
// AES-128 ECB encryptor on AXI-Stream.
// An input packet is a command word, an optional 4-word key (cmd[0]=1), then
// whole 4-word plaintext blocks. Each block is encrypted one round per cycle,
// and the 4 ciphertext words are streamed out before the next block is accepted.
//
// state  | meaning
// CMD    | waiting for the command word
// KEY    | collecting the 4 key words
// DATA   | collecting the 4 plaintext words of a block
// CIPHER | running rounds 1..10, one per cycle
// OUT    | presenting the 4 ciphertext words
module zynq_aes (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic        s00_axis_tlast,
    output logic [31:0] m00_axis_tdata,
    output logic        m00_axis_tvalid,
    input  logic        m00_axis_tready,
    output logic        m00_axis_tlast
);

    typedef enum logic [2:0] {CMD, KEY, DATA, CIPHER, OUT} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state;
    state_t       state_nxt;
    logic [127:0] blk;          // key/plaintext collector, then cipher state
    logic [127:0] key_reg;
    logic [127:0] rk;           // round key of the previous round
    logic [1:0]   word_cnt;
    logic [3:0]   round_left;
    logic         last_blk;
    logic         run;          // holds tready low until the first edge after reset
    logic         s_hs;
    logic         m_hs;
    logic [127:0] blk_shift;
    logic [127:0] rk_nxt;
    logic [127:0] round_out;
    logic [7:0]   rcon;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] pos;
        pos = 11'd2047 - {x, 3'b000};
        return SBOX[pos -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3;
        logic [31:0] t;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        return {n0, n1, n2, w3 ^ n2};
    endfunction

    // Byte i of the state sits in column i/4, row i%4 (byte 0 in the MSBs).
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic final_rnd);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0;
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [7:0]   a3;
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (final_rnd)
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o ^ k;
    endfunction

    assign s00_axis_tready = run && (state == CMD || state == KEY || state == DATA);
    assign s_hs            = s00_axis_tvalid && s00_axis_tready;
    assign m00_axis_tvalid = (state == OUT);
    assign m_hs            = m00_axis_tvalid && m00_axis_tready;
    assign m00_axis_tlast  = (state == OUT) && last_blk && (word_cnt == 2'd3);
    assign blk_shift       = {blk[95:0], s00_axis_tdata};
    assign rk_nxt          = key_expand(rk, rcon);
    assign round_out       = aes_round(blk, rk_nxt, round_left == 4'd1);

    // Rcon follows the round number, which counts up as round_left counts down.
    always_comb begin
        rcon = 8'h00;
        case (round_left)
            4'd10:   rcon = 8'h01;
            4'd9:    rcon = 8'h02;
            4'd8:    rcon = 8'h04;
            4'd7:    rcon = 8'h08;
            4'd6:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd4:    rcon = 8'h40;
            4'd3:    rcon = 8'h80;
            4'd2:    rcon = 8'h1b;
            4'd1:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Output word mux, ciphertext bytes 0-3 first; zero outside OUT.
    always_comb begin
        m00_axis_tdata = 32'h0;
        if (state == OUT) begin
            case (word_cnt)
                2'd0:    m00_axis_tdata = blk[127:96];
                2'd1:    m00_axis_tdata = blk[95:64];
                2'd2:    m00_axis_tdata = blk[63:32];
                default: m00_axis_tdata = blk[31:0];
            endcase
        end
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= CMD;
        else          state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            CMD:
                if (s_hs && !s00_axis_tlast)
                    state_nxt = s00_axis_tdata[0] ? KEY : DATA;
            KEY:
                if (s_hs) begin
                    if (s00_axis_tlast)         state_nxt = CMD;
                    else if (word_cnt == 2'd3) state_nxt = DATA;
                end
            DATA:
                if (s_hs) begin
                    if (word_cnt == 2'd3)    state_nxt = CIPHER;
                    else if (s00_axis_tlast) state_nxt = CMD;
                end
            CIPHER:
                if (round_left == 4'd1) state_nxt = OUT;
            OUT:
                if (m_hs && word_cnt == 2'd3) state_nxt = last_blk ? CMD : DATA;
            default: state_nxt = CMD;
        endcase
    end

    // Datapath: word collection, key load, round iteration and output word count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            run        <= 1'b0;
            blk        <= '0;
            key_reg    <= '0;
            rk         <= '0;
            word_cnt   <= '0;
            round_left <= '0;
            last_blk   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                CMD:
                    if (s_hs) word_cnt <= '0;
                KEY:
                    if (s_hs) begin
                        blk      <= blk_shift;
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3)    key_reg  <= blk_shift;
                        else if (s00_axis_tlast) word_cnt <= '0;
                    end
                DATA:
                    if (s_hs) begin
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            blk        <= blk_shift ^ key_reg;
                            rk         <= key_reg;
                            last_blk   <= s00_axis_tlast;
                            round_left <= 4'd10;
                        end else begin
                            blk <= blk_shift;
                            if (s00_axis_tlast) word_cnt <= '0;
                        end
                    end
                CIPHER: begin
                    blk        <= round_out;
                    rk         <= rk_nxt;
                    round_left <= round_left - 4'd1;
                end
                OUT:
                    if (m_hs) word_cnt <= word_cnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zynq_aes.sv
// Bench for zynq_aes: known-answer vectors from a table plus hand-written
// sequences for key reuse, multi-block packets, back-pressure, truncated
// packets and reset during encryption. Output words are matched against a
// queue of expected words filled when the stimulus is driven.
module tb_zynq_aes;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    zynq_aes dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    vec_t vecs [6];
    exp_t exp_q [$];

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_acc  = 0;
    int rise_cyc  = -1;
    int out_cnt   = 0;
    int stall_cnt = 0;
    bit stall_mode = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: always high, or 8 cycles low / 1 cycle high.
    initial begin
        int ph;
        ph = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (stall_mode) begin
                m_tready = (ph == 8);
                ph = (ph == 8) ? 0 : ph + 1;
            end else begin
                m_tready = 1'b1;
                ph = 0;
            end
        end
    end

    // Output monitor: scoreboard pop, hold-while-stalled and first-valid timing.
    initial begin
        logic        prev_v;
        logic        prev_r;
        logic [31:0] prev_d;
        logic        prev_l;
        exp_t        e;
        prev_v = 1'b0;
        prev_r = 1'b1;
        prev_d = '0;
        prev_l = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_v = 1'b0;
            end else begin
                if (m_tvalid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
                if (prev_v && !prev_r) begin
                    stall_cnt++;
                    chk("stall_valid", {127'b0, m_tvalid}, 128'd1);
                    chk("stall_data", {96'b0, m_tdata}, {96'b0, prev_d});
                    chk("stall_last", {127'b0, m_tlast}, {127'b0, prev_l});
                end
                if (m_tvalid && m_tready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h with nothing expected", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", {96'b0, m_tdata}, {96'b0, e.d});
                        chk("out_last", {127'b0, m_tlast}, {127'b0, e.l});
                    end
                end
                prev_v = m_tvalid;
                prev_r = m_tready;
                prev_d = m_tdata;
                prev_l = m_tlast;
            end
        end
    end

    task automatic send(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        s_tdata  = w;
        s_tvalid = 1'b1;
        s_tlast  = l;
        @(negedge aclk);
        while (!s_tready && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: tready stayed %b for word %h", s_tready, w);
        end
        last_acc = cyc;
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic push_block(input logic [127:0] ct, input logic last);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.d = ct[127-32*i -: 32];
            e.l = last && (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_key(input logic [127:0] k, input logic last);
        for (int i = 0; i < 4; i++) send(k[127-32*i -: 32], last && (i == 3));
    endtask

    task automatic send_block(input logic [127:0] pt, input logic [127:0] ct,
                              input logic last, input logic push);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && push) push_block(ct, last);
            send(pt[127-32*i -: 32], last && (i == 3));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge aclk);
            n++;
        end
        #1;
        chk(name, exp_q.size(), 128'd0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin
        int acc;
        int base;
        logic [127:0] k_c1;
        logic [127:0] p_c1;
        logic [127:0] c_c1;
        logic [127:0] k_sp;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    128'hf5d3d58503b9699de785895a96fdbaaf};
        vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf69f2445df4f9b17ad2b417be66c3710,
                    128'h7b0c785e27e8ad3f8223207104725dd4};
        vecs[5] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        k_c1 = vecs[0].key;
        p_c1 = vecs[0].pt;
        c_c1 = vecs[0].ct;
        k_sp = vecs[2].key;

        aresetn  = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_s_tready", {127'b0, s_tready}, 128'd0);
        chk("rst_m_tvalid", {127'b0, m_tvalid}, 128'd0);
        chk("rst_m_tlast", {127'b0, m_tlast}, 128'd0);
        chk("rst_m_tdata", {96'b0, m_tdata}, 128'd0);
        aresetn = 1'b1;
        #1;
        chk("rel_tready_before_edge", {127'b0, s_tready}, 128'd0);
        @(posedge aclk);
        #1;
        chk("rel_tready_after_edge", {127'b0, s_tready}, 128'd1);

        // Known-answer table; odd entries use a command word with the ignored bits set.
        for (int v = 0; v < 6; v++) begin
            rise_cyc = -1;
            send((v % 2) ? 32'hffff_ffff : 32'h0000_0001, 1'b0);
            send_key(vecs[v].key, 1'b0);
            send_block(vecs[v].pt, vecs[v].ct, 1'b1, 1'b1);
            acc = last_acc;
            drain("table_drain");
            chk("table_latency", rise_cyc - acc, 128'd11);
        end

        // Key-only packet, then a data-only packet reusing that key.
        base = out_cnt;
        send(32'h1, 1'b0);
        send_key(k_c1, 1'b1);
        idle(20);
        chk("keyonly_no_out", out_cnt - base, 128'd0);
        send(32'hffff_fffe, 1'b0);
        send_block(p_c1, c_c1, 1'b1, 1'b1);
        drain("reuse_drain");

        // Lone command word carrying tlast, then a normal packet.
        base = out_cnt;
        send(32'h1, 1'b1);
        idle(20);
        chk("cmd_tlast_no_out", out_cnt - base, 128'd0);
        chk("cmd_tlast_ready", {127'b0, s_tready}, 128'd1);
        send(32'h0, 1'b0);
        send_block(p_c1, c_c1, 1'b1, 1'b1);
        drain("cmd_tlast_drain");

        // Two blocks in one packet.
        rise_cyc = -1;
        send(32'h1, 1'b0);
        send_key(k_sp, 1'b0);
        send_block(vecs[2].pt, vecs[2].ct, 1'b0, 1'b1);
        acc = last_acc;
        send_block(vecs[3].pt, vecs[3].ct, 1'b1, 1'b1);
        drain("two_blk_drain");
        chk("two_blk_latency", rise_cyc - acc, 128'd11);

        // Same data under 8-low/1-high back-pressure, three blocks.
        stall_mode = 1'b1;
        send(32'h0, 1'b0);
        send_block(vecs[2].pt, vecs[2].ct, 1'b0, 1'b1);
        send_block(vecs[3].pt, vecs[3].ct, 1'b0, 1'b1);
        send_block(vecs[4].pt, vecs[4].ct, 1'b1, 1'b1);
        drain("stall_drain");
        stall_mode = 1'b0;
        idle(2);
        chk("stall_seen", {127'b0, stall_cnt > 20}, 128'd1);

        // Packet truncated on the 2nd data word.
        base = out_cnt;
        send(32'h0, 1'b0);
        send(32'hdead_beef, 1'b0);
        send(32'h0123_4567, 1'b1);
        idle(20);
        chk("partial_no_out", out_cnt - base, 128'd0);
        send(32'h0, 1'b0);
        send_block(vecs[4].pt, vecs[4].ct, 1'b1, 1'b1);
        drain("partial_drain");

        // Truncated key must not overwrite the stored key.
        send(32'h1, 1'b0);
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b1);
        send(32'h0, 1'b0);
        send_block(vecs[2].pt, vecs[2].ct, 1'b1, 1'b1);
        drain("partial_key_drain");

        // Reset during CIPHER: no output, key cleared, next packets fine.
        base = out_cnt;
        send(32'h0, 1'b0);
        send_block(vecs[3].pt, vecs[3].ct, 1'b1, 1'b0);
        @(negedge aclk);
        chk("cipher_tready", {127'b0, s_tready}, 128'd0);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("midrst_tready", {127'b0, s_tready}, 128'd0);
        chk("midrst_tvalid", {127'b0, m_tvalid}, 128'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        idle(30);
        chk("midrst_no_out", out_cnt - base, 128'd0);
        send(32'h0, 1'b0);
        send_block(vecs[5].pt, vecs[5].ct, 1'b1, 1'b1);
        drain("post_rst_zero_key");
        send(32'h1, 1'b0);
        send_key(vecs[1].key, 1'b0);
        send_block(vecs[1].pt, vecs[1].ct, 1'b1, 1'b1);
        drain("post_rst_drain");

        idle(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
